trace_mac_array: RTL and testbench
==================================

# trace_mac_array

Parametrised, streaming successor to the fixed two-column trace unit: computes tr(Yᴴ·G), or tr(Yᵀ·G), for NR×NT complex matrices Y and G. Both matrices arrive row by row over a valid/ready handshake, with all NT columns presented in parallel. The block feeds the x-metric calculator numerator. Accumulation runs at full product precision, and the result is rescaled and saturated once to N bits.

## Interface
- N, 16: sample width, signed two's complement.
- Q, 8: fractional bits of inputs and output.
- NT, 2: number of columns (parallel lanes); at least 1.
- NR, 4: number of rows (beats per matrix); at least 1.
- ACC_WIDTH, 40: accumulator width. Must satisfy ACC_WIDTH ≥ 2N+1+clog2(NR·NT).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  single-cycle pulse that begins a new matrix; honoured only in IDLE
- abort  in  1  synchronous; returns to IDLE from any state, no done
- conj_mode  in  1  1 = conj(y)·g (Yᴴ·G), 0 = y·g (Yᵀ·G); sampled on start
- in_valid  in  1  row beat valid
- in_ready  out  1  high only in ACCUM
- y_r, y_i  in  NT*N  row r of Y; lane k occupies bits [k*N +: N]
- g_r, g_i  in  NT*N  row r of G; same packing
- trace_r, trace_i  out  N  result; held until the next done
- done  out  1  one-cycle pulse when trace_r/trace_i update
- busy  out  1  high in ACCUM and REDUCE
- sat_flag  out  1  set if either component saturated; updates with done

## Operation
- States: IDLE, ACCUM, REDUCE.
- IDLE, start=1: clear all NT lane accumulators (re and im), latch conj_mode, clear row counter, go to ACCUM.
- ACCUM: a beat is accepted when in_valid && in_ready. For each lane k the block computes the product p = a·b, where a = y[k] (conjugated when conj_mode=1) and b = g[k]:
  - conj: re = yr·gr + yi·gi, im = yr·gi − yi·gr
  - no conj: re = yr·gr − yi·gi, im = yr·gi + yi·gr
- Products are 2N-bit signed with 2Q fractional bits. They are sign-extended and added to the ACC_WIDTH lane accumulators, with no rounding.
- The row counter increments per accepted beat. After beat NR is accepted, the FSM moves to REDUCE. Cycles with in_valid=0 are idle and have no effect.
- REDUCE (one cycle):
  - Sum all NT lane accumulators.
  - Arithmetic shift right by Q (truncation toward −∞).
  - Saturate to [−2^(N−1), 2^(N−1)−1].
  - Register the result into trace_r/trace_i and sat_flag, pulse done, return to IDLE.
- start outside IDLE is ignored. start and abort in the same cycle: abort wins.
- abort: accumulators are left as-is (they are cleared on the next start); outputs keep their previous result; busy drops next cycle.
- Reset (rst=0, asynchronous): state IDLE; trace_r, trace_i, done, busy, sat_flag, in_ready and the counters go to 0. This applies even mid-ACCUM; any partial sum is discarded.

## Timing
- start at cycle t: in_ready=1 and busy=1 from t+1.
- Back-to-back beats are allowed (throughput one row per cycle). NR beats with no gaps are accepted at t+1..t+NR.
- Last beat accepted at cycle c: in_ready=0 at c+1 (REDUCE). trace_r/trace_i, sat_flag and done=1 are visible at c+2. busy=0 at c+2.
- Earliest next start is at c+2 (the IDLE cycle coinciding with done). Minimum matrix period is NR+2 cycles.
- in_ready is a registered state decode; it never depends combinationally on in_valid.

## Test plan
- Identity: Q=8, NT=2, NR=4, conj_mode=1, every y=g=256+0j, gap-free → trace_r=2048, trace_i=0, sat_flag=0, done exactly 2 cycles after the 4th beat.
- Conjugation: every y=g=0+256j → conj_mode=1 gives trace_r=2048, trace_i=0; conj_mode=0 gives trace_r=−2048, trace_i=0. Also y=256+0j, g=0+256j with conj_mode=1 → trace_r=0, trace_i=2048.
- Saturation: every y=g=32767+0j → trace_r=32767, sat_flag=1. Every y=32767, g=−32768 → trace_r=−32768, sat_flag=1. A following identity matrix clears sat_flag to 0.
- Backpressure and ignore rules: in_valid toggled 1,0,1,0… → same 2048 result, done 2 cycles after the 4th accepted beat. start pulsed during ACCUM → no restart, result unchanged.
- Reset mid-operation: rst=0 after 2 accepted beats → all outputs 0 immediately, in_ready=0. After release, a fresh start plus 4 identity beats → 2048 (no residue from the aborted matrix).
- Abort: abort after 3 beats → no done pulse, trace_r keeps its previous value, busy=0 next cycle. A new matrix then computes correctly. Repeat with parameters NT=4, NR=8, ACC_WIDTH=40, identity input → trace_r=8192.

Source files
------------

// File: rtl/trace_mac_array_if.sv
// Row-beat stream carrying one row of Y and G, NT complex lanes wide,
// with a valid/ready handshake.
interface trace_mac_array_if #(
  parameter int N  = 16,
  parameter int NT = 2
);
  logic            in_valid;
  logic            in_ready;
  logic [NT*N-1:0] y_r;
  logic [NT*N-1:0] y_i;
  logic [NT*N-1:0] g_r;
  logic [NT*N-1:0] g_i;

  modport master (output in_valid, y_r, y_i, g_r, g_i, input in_ready);
  modport slave  (input in_valid, y_r, y_i, g_r, g_i, output in_ready);
endinterface

// File: rtl/trace_mac_array.sv
// Streaming complex trace tr(Y^H G) / tr(Y^T G): NT parallel lane MACs at full
// product precision, one lane reduction, one rescale and saturation per matrix.
module trace_mac_array #(
  parameter int N         = 16,
  parameter int Q         = 8,
  parameter int NT        = 2,
  parameter int NR        = 4,
  parameter int ACC_WIDTH = 40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                conj_mode,
  trace_mac_array_if.slave    s_in,
  output logic signed [N-1:0] trace_r,
  output logic signed [N-1:0] trace_i,
  output logic                done,
  output logic                busy,
  output logic                sat_flag
);

  localparam int PW = 2 * N + 1;
  localparam int CW = (NR > 1) ? $clog2(NR) : 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(NR - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {{(ACC_WIDTH-N+1){1'b1}}, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_REDUCE
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic                        r_conj;
  logic [CW-1:0]               r_row;
  logic signed [ACC_WIDTH-1:0] r_acc_re [NT];
  logic signed [ACC_WIDTH-1:0] r_acc_im [NT];
  logic signed [N-1:0]         r_trace_r;
  logic signed [N-1:0]         r_trace_i;
  logic                        r_done;
  logic                        r_sat;

  logic                        w_beat;
  logic signed [PW-1:0]        w_p_re [NT];
  logic signed [PW-1:0]        w_p_im [NT];
  logic signed [ACC_WIDTH-1:0] w_sum_re;
  logic signed [ACC_WIDTH-1:0] w_sum_im;
  logic signed [ACC_WIDTH-1:0] w_sh_re;
  logic signed [ACC_WIDTH-1:0] w_sh_im;
  logic signed [N-1:0]         w_sat_re;
  logic signed [N-1:0]         w_sat_im;
  logic                        w_ovf_re;
  logic                        w_ovf_im;

  // Operands widened to PW so sums of two products (up to 2^(2N-1)) cannot wrap.
  function automatic logic signed [PW-1:0] sext(input logic [N-1:0] x);
    return {{(N+1){x[N-1]}}, x};
  endfunction

  assign s_in.in_ready = (r_state == S_ACCUM);
  assign busy          = (r_state != S_IDLE);
  assign w_beat        = s_in.in_valid && s_in.in_ready;
  assign trace_r       = r_trace_r;
  assign trace_i       = r_trace_i;
  assign done          = r_done;
  assign sat_flag      = r_sat;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_ACCUM;
      S_ACCUM:  if (w_beat && (r_row == LAST_ROW)) w_next = S_REDUCE;
      S_REDUCE: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  always_comb begin
    for (int unsigned k = 0; k < NT; k++) begin
      w_p_re[k] = '0;
      w_p_im[k] = '0;
    end
    for (int unsigned k = 0; k < NT; k++) begin
      if (r_conj) begin
        w_p_re[k] = sext(s_in.y_r[k*N +: N]) * sext(s_in.g_r[k*N +: N])
                  + sext(s_in.y_i[k*N +: N]) * sext(s_in.g_i[k*N +: N]);
        w_p_im[k] = sext(s_in.y_r[k*N +: N]) * sext(s_in.g_i[k*N +: N])
                  - sext(s_in.y_i[k*N +: N]) * sext(s_in.g_r[k*N +: N]);
      end else begin
        w_p_re[k] = sext(s_in.y_r[k*N +: N]) * sext(s_in.g_r[k*N +: N])
                  - sext(s_in.y_i[k*N +: N]) * sext(s_in.g_i[k*N +: N]);
        w_p_im[k] = sext(s_in.y_r[k*N +: N]) * sext(s_in.g_i[k*N +: N])
                  + sext(s_in.y_i[k*N +: N]) * sext(s_in.g_r[k*N +: N]);
      end
    end
  end

  always_comb begin
    w_sum_re = '0;
    w_sum_im = '0;
    for (int unsigned k = 0; k < NT; k++) begin
      w_sum_re = w_sum_re + r_acc_re[k];
      w_sum_im = w_sum_im + r_acc_im[k];
    end
    w_sh_re  = w_sum_re >>> Q;
    w_sh_im  = w_sum_im >>> Q;
    w_ovf_re = (w_sh_re > SAT_MAX) || (w_sh_re < SAT_MIN);
    w_ovf_im = (w_sh_im > SAT_MAX) || (w_sh_im < SAT_MIN);
    w_sat_re = w_sh_re[N-1:0];
    w_sat_im = w_sh_im[N-1:0];
    if (w_sh_re > SAT_MAX) w_sat_re = SAT_MAX[N-1:0];
    if (w_sh_re < SAT_MIN) w_sat_re = SAT_MIN[N-1:0];
    if (w_sh_im > SAT_MAX) w_sat_im = SAT_MAX[N-1:0];
    if (w_sh_im < SAT_MIN) w_sat_im = SAT_MIN[N-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_conj    <= 1'b0;
      r_row     <= '0;
      r_trace_r <= '0;
      r_trace_i <= '0;
      r_done    <= 1'b0;
      r_sat     <= 1'b0;
      for (int unsigned k = 0; k < NT; k++) begin
        r_acc_re[k] <= '0;
        r_acc_im[k] <= '0;
      end
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      if ((r_state == S_IDLE) && start && !abort) begin
        r_conj <= conj_mode;
        r_row  <= '0;
        for (int unsigned k = 0; k < NT; k++) begin
          r_acc_re[k] <= '0;
          r_acc_im[k] <= '0;
        end
      end
      if (w_beat) begin
        r_row <= r_row + CW'(1);
        for (int unsigned k = 0; k < NT; k++) begin
          r_acc_re[k] <= r_acc_re[k] + {{(ACC_WIDTH-PW){w_p_re[k][PW-1]}}, w_p_re[k]};
          r_acc_im[k] <= r_acc_im[k] + {{(ACC_WIDTH-PW){w_p_im[k][PW-1]}}, w_p_im[k]};
        end
      end
      if ((r_state == S_REDUCE) && !abort) begin
        r_trace_r <= w_sat_re;
        r_trace_i <= w_sat_im;
        r_sat     <= w_ovf_re || w_ovf_im;
        r_done    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trace_mac_array.sv
// Bench for trace_mac_array: directed vector table, randomized matrices against
// an arithmetic trace model, and reset/abort/backpressure sequences.
module tb_trace_mac_array;
  localparam int N   = 16;
  localparam int NT  = 2;
  localparam int NR  = 4;
  localparam int NT2 = 4;
  localparam int NR2 = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, abort = 1'b0, conj_mode = 1'b0;
  logic start2 = 1'b0, abort2 = 1'b0;
  logic signed [N-1:0] trace_r, trace_i, trace2_r, trace2_i;
  logic done, busy, sat_flag, done2, busy2, sat2;

  trace_mac_array_if #(.N(N), .NT(NT))  if1 ();
  trace_mac_array_if #(.N(N), .NT(NT2)) if2 ();

  trace_mac_array #(.N(N), .Q(8), .NT(NT), .NR(NR), .ACC_WIDTH(40)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .conj_mode(conj_mode),
    .s_in(if1), .trace_r(trace_r), .trace_i(trace_i), .done(done), .busy(busy),
    .sat_flag(sat_flag)
  );

  trace_mac_array #(.N(N), .Q(8), .NT(NT2), .NR(NR2), .ACC_WIDTH(40)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .conj_mode(1'b1),
    .s_in(if2), .trace_r(trace2_r), .trace_i(trace2_i), .done(done2), .busy(busy2),
    .sat_flag(sat2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [N-1:0] m_yr [NR][NT];
  logic signed [N-1:0] m_yi [NR][NT];
  logic signed [N-1:0] m_gr [NR][NT];
  logic signed [N-1:0] m_gi [NR][NT];

  typedef struct {
    bit conj;
    int yr, yi, gr, gi;
    int er, ei;
    bit es;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int yr, input int yi, input int gr, input int gi);
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < NT; k++) begin
        m_yr[r][k] = 16'(yr); m_yi[r][k] = 16'(yi);
        m_gr[r][k] = 16'(gr); m_gi[r][k] = 16'(gi);
      end
  endtask

  task automatic drive_row(input int r);
    for (int k = 0; k < NT; k++) begin
      if1.y_r[k*N +: N] = m_yr[r][k];
      if1.y_i[k*N +: N] = m_yi[r][k];
      if1.g_r[k*N +: N] = m_gr[r][k];
      if1.g_i[k*N +: N] = m_gi[r][k];
    end
  endtask

  // Plain complex arithmetic: sum over all elements, floor-divide by 2^8, clamp.
  task automatic model(input bit conj, output longint er, output longint ei, output bit es);
    longint sr = 0, si = 0, yr, yi, gr, gi;
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < NT; k++) begin
        yr = m_yr[r][k]; yi = m_yi[r][k]; gr = m_gr[r][k]; gi = m_gi[r][k];
        if (conj) yi = -yi;
        sr += yr * gr - yi * gi;
        si += yr * gi + yi * gr;
      end
    sr = sr >>> 8;
    si = si >>> 8;
    es = 1'b0;
    er = sr; ei = si;
    if (sr > 32767)  begin er = 32767;  es = 1'b1; end
    if (sr < -32768) begin er = -32768; es = 1'b1; end
    if (si > 32767)  begin ei = 32767;  es = 1'b1; end
    if (si < -32768) begin ei = -32768; es = 1'b1; end
  endtask

  // Called in IDLE, #1 after an edge; returns #1 after the edge that raises done.
  task automatic run_matrix(input bit conj, input bit gaps, input bit start_mid, input string tag);
    start = 1'b1; conj_mode = conj;
    tick();
    start = 1'b0; conj_mode = ~conj;
    check({tag, "_ready_after_start"}, if1.in_ready, 1);
    check({tag, "_busy_after_start"}, busy, 1);
    for (int r = 0; r < NR; r++) begin
      if (gaps && r > 0) begin
        if1.in_valid = 1'b0;
        if (start_mid) start = 1'b1;
        tick();
        start = 1'b0;
      end
      drive_row(r);
      if1.in_valid = 1'b1;
      tick();
    end
    if1.in_valid = 1'b0;
    check({tag, "_reduce_ready"}, if1.in_ready, 0);
    check({tag, "_reduce_done"}, done, 0);
    tick();
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_end"}, busy, 0);
  endtask

  longint er, ei;
  bit     es;
  int     dcount;

  initial begin
    vecs[0] = '{1, 256, 0, 256, 0, 2048, 0, 0};
    vecs[1] = '{1, 0, 256, 0, 256, 2048, 0, 0};
    vecs[2] = '{0, 0, 256, 0, 256, -2048, 0, 0};
    vecs[3] = '{1, 256, 0, 0, 256, 0, 2048, 0};
    vecs[4] = '{1, 32767, 0, 32767, 0, 32767, 0, 1};
    vecs[5] = '{1, 32767, 0, -32768, 0, -32768, 0, 1};
    vecs[6] = '{1, 256, 0, 256, 0, 2048, 0, 0};

    if1.in_valid = 1'b0; if1.y_r = '0; if1.y_i = '0; if1.g_r = '0; if1.g_i = '0;
    if2.in_valid = 1'b0; if2.y_r = '0; if2.y_i = '0; if2.g_r = '0; if2.g_i = '0;
    repeat (3) tick();
    check("rst_trace_r", trace_r, 0);
    check("rst_trace_i", trace_i, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_ready", if1.in_ready, 0);
    rst = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      fill(vecs[v].yr, vecs[v].yi, vecs[v].gr, vecs[v].gi);
      run_matrix(vecs[v].conj, 1'b0, 1'b0, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_tr", v), trace_r, vecs[v].er);
      check($sformatf("vec%0d_ti", v), trace_i, vecs[v].ei);
      check($sformatf("vec%0d_sat", v), sat_flag, vecs[v].es);
    end

    fill(256, 0, 256, 0);
    run_matrix(1'b1, 1'b1, 1'b1, "bp");
    check("bp_tr", trace_r, 2048);
    check("bp_ti", trace_i, 0);
    tick();
    check("bp_done_single", done, 0);

    for (int it = 0; it < 16; it++) begin
      bit c;
      c = 1'($urandom);
      for (int r = 0; r < NR; r++)
        for (int k = 0; k < NT; k++) begin
          if (it % 2 == 0) begin
            m_yr[r][k] = 16'($signed($urandom_range(0, 4095)) - 2048);
            m_yi[r][k] = 16'($signed($urandom_range(0, 4095)) - 2048);
            m_gr[r][k] = 16'($signed($urandom_range(0, 4095)) - 2048);
            m_gi[r][k] = 16'($signed($urandom_range(0, 4095)) - 2048);
          end else begin
            m_yr[r][k] = 16'($urandom); m_yi[r][k] = 16'($urandom);
            m_gr[r][k] = 16'($urandom); m_gi[r][k] = 16'($urandom);
          end
        end
      model(c, er, ei, es);
      run_matrix(c, 1'($urandom), 1'b0, $sformatf("rnd%0d", it));
      check($sformatf("rnd%0d_tr", it), trace_r, er);
      check($sformatf("rnd%0d_ti", it), trace_i, ei);
      check($sformatf("rnd%0d_sat", it), sat_flag, es);
    end

    fill(256, 0, 256, 0);
    run_matrix(1'b1, 1'b0, 1'b0, "pre_rst");
    fill(1000, 300, 1000, 300);
    start = 1'b1; conj_mode = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < 2; r++) begin
      drive_row(r); if1.in_valid = 1'b1; tick();
    end
    rst = 1'b0;
    #1;
    check("mid_rst_tr", trace_r, 0);
    check("mid_rst_ti", trace_i, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", if1.in_ready, 0);
    check("mid_rst_done", done, 0);
    if1.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    fill(256, 0, 256, 0);
    run_matrix(1'b1, 1'b0, 1'b0, "post_rst");
    check("post_rst_tr", trace_r, 2048);
    check("post_rst_ti", trace_i, 0);

    fill(0, 256, 0, 256);
    run_matrix(1'b0, 1'b0, 1'b0, "pre_abort");
    check("pre_abort_tr", trace_r, -2048);
    fill(700, 0, 700, 0);
    start = 1'b1; conj_mode = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      drive_row(r); if1.in_valid = 1'b1; tick();
    end
    if1.in_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_ready", if1.in_ready, 0);
    dcount = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) dcount++;
      tick();
    end
    check("abort_no_done", dcount, 0);
    check("abort_keep_tr", trace_r, -2048);
    fill(256, 0, 256, 0);
    run_matrix(1'b1, 1'b0, 1'b0, "post_abort");
    check("post_abort_tr", trace_r, 2048);

    if2.y_r = {NT2{16'sd256}}; if2.y_i = '0;
    if2.g_r = {NT2{16'sd256}}; if2.g_i = '0;
    start2 = 1'b1; tick(); start2 = 1'b0;
    if2.in_valid = 1'b1;
    repeat (3) tick();
    if2.in_valid = 1'b0;
    abort2 = 1'b1; tick(); abort2 = 1'b0;
    check("w_abort_busy", busy2, 0);
    check("w_abort_tr", trace2_r, 0);
    start2 = 1'b1; tick(); start2 = 1'b0;
    if2.in_valid = 1'b1;
    repeat (NR2) tick();
    if2.in_valid = 1'b0;
    check("w_reduce_done", done2, 0);
    tick();
    check("w_done", done2, 1);
    check("w_tr", trace2_r, 8192);
    check("w_ti", trace2_i, 0);
    check("w_sat", sat2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
